// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the microinstruction-store RAM arbiter.
// Owner encoding, requester indices and default geometry live here.
package ram_arb_pkg;

  localparam int RAM_WIDTH_DEF = 16;
  localparam int ADDR_SIZE_DEF = 10;
  localparam int RAM_DEPTH_DEF = 1024;
  localparam int MAX_LOCK_DEF  = 8;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  // Maps a requester select bit (0 = A, 1 = B) onto its locked-owner state.
  function automatic owner_t owner_of(input logic sel);
    return sel ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/ram_sp_core.sv
// Single-port RAM: synchronous write, registered read.
// The array is never reset; only the read register is cleared.
module ram_sp_core #(
  parameter int RAM_WIDTH = 16,
  parameter int ADDR_SIZE = 10,
  parameter int RAM_DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_enb,
  input  logic                 rd_enb,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [RAM_WIDTH-1:0] data_in,
  output logic [RAM_WIDTH-1:0] data_out
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_enb) mem[addr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (rd_enb) begin
      data_out <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter for two requesters sharing the microinstruction RAM,
// with bounded beat locking and one-cycle read return to the issuing side.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int RAM_WIDTH = RAM_WIDTH_DEF,
  parameter int RAM_DEPTH = RAM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int MAX_LOCK  = MAX_LOCK_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic                 a_we,
  input  logic                 a_lock,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [RAM_WIDTH-1:0] a_wdata,
  output logic                 a_rvalid,
  output logic [RAM_WIDTH-1:0] a_rdata,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic                 b_we,
  input  logic                 b_lock,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [RAM_WIDTH-1:0] b_wdata,
  output logic                 b_rvalid,
  output logic [RAM_WIDTH-1:0] b_rdata
);

  localparam int                CNT_W   = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_LOCK);

  owner_t           owner_reg;
  logic             rr_reg;        // 0 -> A has priority, 1 -> B
  logic [CNT_W-1:0] lock_cnt_reg;
  logic [1:0]       rvalid_reg;

  logic [1:0]       we;
  logic [1:0]       lock;
  logic [1:0]       grant;
  logic             beat;
  logic             gsel;          // granted side, meaningful only with beat

  logic                 ram_wr_enb;
  logic                 ram_rd_enb;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [RAM_WIDTH-1:0] ram_wdata;
  logic [RAM_WIDTH-1:0] ram_rdata;

  assign we   = {b_we, a_we};
  assign lock = {b_lock, a_lock};

  // A lock only holds while its owner keeps requesting; once saturated it
  // yields to a waiting peer, otherwise normal round-robin decides.
  always_comb begin
    grant = '0;
    if (owner_reg == OWN_A && a_valid) begin
      if (lock_cnt_reg < MAX_CNT || !b_valid) grant[REQ_A] = 1'b1;
      else                                    grant[REQ_B] = 1'b1;
    end else if (owner_reg == OWN_B && b_valid) begin
      if (lock_cnt_reg < MAX_CNT || !a_valid) grant[REQ_B] = 1'b1;
      else                                    grant[REQ_A] = 1'b1;
    end else if (a_valid && b_valid) begin
      if (rr_reg) grant[REQ_B] = 1'b1;
      else        grant[REQ_A] = 1'b1;
    end else if (a_valid) begin
      grant[REQ_A] = 1'b1;
    end else if (b_valid) begin
      grant[REQ_B] = 1'b1;
    end
  end

  assign beat    = |grant;
  assign gsel    = grant[REQ_B];
  assign a_ready = grant[REQ_A];
  assign b_ready = grant[REQ_B];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg    <= OWN_NONE;
      rr_reg       <= 1'b0;
      lock_cnt_reg <= '0;
      rvalid_reg   <= '0;
    end else begin
      rvalid_reg <= grant & ~we;
      if (beat && lock[gsel]) begin
        rr_reg    <= ~gsel;
        owner_reg <= owner_of(gsel);
        if (owner_reg == owner_of(gsel))
          lock_cnt_reg <= (lock_cnt_reg == MAX_CNT) ? MAX_CNT : lock_cnt_reg + 1'b1;
        else
          lock_cnt_reg <= CNT_W'(1);
      end else begin
        if (beat) rr_reg <= ~gsel;
        owner_reg    <= OWN_NONE;
        lock_cnt_reg <= '0;
      end
    end
  end

  assign ram_wr_enb = beat && we[gsel];
  assign ram_rd_enb = beat && !we[gsel];
  assign ram_addr   = gsel ? b_addr  : a_addr;
  assign ram_wdata  = gsel ? b_wdata : a_wdata;

  ram_sp_core #(
    .RAM_WIDTH (RAM_WIDTH),
    .ADDR_SIZE (ADDR_SIZE),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_enb   (ram_wr_enb),
    .rd_enb   (ram_rd_enb),
    .addr     (ram_addr),
    .data_in  (ram_wdata),
    .data_out (ram_rdata)
  );

  assign a_rvalid = rvalid_reg[REQ_A];
  assign b_rvalid = rvalid_reg[REQ_B];
  assign a_rdata  = ram_rdata;
  assign b_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, well away from the rising edge.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_we, a_lock;
  logic [9:0]  a_addr;
  logic [15:0] a_wdata;
  logic        a_ready, a_rvalid;
  logic [15:0] a_rdata;
  logic        b_valid, b_we, b_lock;
  logic [9:0]  b_addr;
  logic [15:0] b_wdata;
  logic        b_ready, b_rvalid;
  logic [15:0] b_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_we     (a_we),
    .a_lock   (a_lock),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_we     (b_we),
    .b_lock   (b_lock),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata)
  );

  // One line per accepted beat.
  always @(posedge clk) begin
    if (rst_n && a_valid && a_ready)
      $display("[%0t] beat A we=%0b lock=%0b addr=%03h wdata=%04h", $time, a_we, a_lock, a_addr, a_wdata);
    if (rst_n && b_valid && b_ready)
      $display("[%0t] beat B we=%0b lock=%0b addr=%03h wdata=%04h", $time, b_we, b_lock, b_addr, b_wdata);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_a(input logic v, input logic w, input logic l, input logic [9:0] ad, input logic [15:0] d);
    a_valid = v; a_we = w; a_lock = l; a_addr = ad; a_wdata = d;
  endtask

  task automatic drive_b(input logic v, input logic w, input logic l, input logic [9:0] ad, input logic [15:0] d);
    b_valid = v; b_we = w; b_lock = l; b_addr = ad; b_wdata = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_a(0, 0, 0, 10'h0, 16'h0);
    drive_b(0, 0, 0, 10'h0, 16'h0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_a(0, 0, 0, 10'h0, 16'h0);
    drive_b(0, 0, 0, 10'h0, 16'h0);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({a_ready, b_ready, a_rvalid, b_rvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000", {a_ready, b_ready, a_rvalid, b_rvalid});
    end
    checks++;
    if ({a_rdata, b_rdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 00000000", {a_rdata, b_rdata});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({a_ready, b_ready, a_rvalid, b_rvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_ctrl: got %b want 0000", {a_ready, b_ready, a_rvalid, b_rvalid});
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive_a(1, 1, 0, 10'h005, 16'h1234);
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++;
      $display("FAIL wr_ready: got %b want 10", {a_ready, b_ready});
    end
    @(negedge clk);
    drive_a(1, 0, 0, 10'h005, 16'h0);
    #1;
    checks++;
    if ({a_ready, a_rvalid, b_rvalid} !== 3'b100) begin
      errors++;
      $display("FAIL rd_ready: got %b want 100", {a_ready, a_rvalid, b_rvalid});
    end
    @(negedge clk);
    drive_a(0, 0, 0, 10'h0, 16'h0);
    #1;
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b10 || a_rdata !== 16'h1234) begin
      errors++;
      $display("FAIL rd_data: got rvalid=%b rdata=%h want 10 1234", {a_rvalid, b_rvalid}, a_rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rd_pulse: got %b want 00", {a_rvalid, b_rvalid});
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g, exp_v;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_a(1, 0, 0, 10'h005, 16'h0);
      drive_b(1, 0, 0, 10'h005, 16'h0);
      #1;
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if ({a_ready, b_ready} !== exp_g) begin
        errors++;
        $display("FAIL alt_grant[%0d]: got %b want %b", i, {a_ready, b_ready}, exp_g);
      end
      if (i > 0) begin
        exp_v = ((i - 1) % 2 == 0) ? 2'b10 : 2'b01;
        checks++;
        if ({a_rvalid, b_rvalid} !== exp_v || a_rdata !== 16'h1234) begin
          errors++;
          $display("FAIL alt_rvalid[%0d]: got %b rdata=%h want %b 1234", i, {a_rvalid, b_rvalid}, a_rdata, exp_v);
        end
      end
    end
    @(negedge clk);
    drive_a(0, 0, 0, 10'h0, 16'h0);
    drive_b(0, 0, 0, 10'h0, 16'h0);
    #1;
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b01) begin
      errors++;
      $display("FAIL alt_last: got %b want 01", {a_rvalid, b_rvalid});
    end
  endtask

  task automatic test_lock_handoff();
    logic [1:0] exp_g;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive_a(1, 0, (i < 9), 10'h005, 16'h0);
      drive_b(1, 0, 0, 10'h005, 16'h0);
      #1;
      if (i < 8)       exp_g = 2'b10;
      else if (i == 8) exp_g = 2'b01;
      else             exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
      checks++;
      if ({a_ready, b_ready} !== exp_g) begin
        errors++;
        $display("FAIL lock_grant[%0d]: got %b want %b", i, {a_ready, b_ready}, exp_g);
      end
      if (i == 9) begin
        checks++;
        if ({a_rvalid, b_rvalid} !== 2'b01) begin
          errors++;
          $display("FAIL lock_b_rvalid: got %b want 01", {a_rvalid, b_rvalid});
        end
      end
    end
    @(negedge clk);
    drive_a(0, 0, 0, 10'h0, 16'h0);
    drive_b(0, 0, 0, 10'h0, 16'h0);
  endtask

  task automatic test_lock_idle();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive_a(1, 0, 1, 10'h005, 16'h0);
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b10) begin
        errors++;
        $display("FAIL idle_lock[%0d]: got %b want 10", i, {a_ready, b_ready});
      end
    end
    @(negedge clk);
    drive_b(1, 0, 0, 10'h005, 16'h0);
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b01) begin
      errors++;
      $display("FAIL sat_handoff: got %b want 01", {a_ready, b_ready});
    end
    @(negedge clk);
    drive_b(0, 0, 0, 10'h0, 16'h0);
    #1;
    checks++;
    if ({a_ready, b_ready, b_rvalid} !== 3'b101) begin
      errors++;
      $display("FAIL sat_resume: got %b want 101", {a_ready, b_ready, b_rvalid});
    end
    @(negedge clk);
    drive_a(0, 0, 0, 10'h0, 16'h0);
  endtask

  task automatic test_contention_wrap();
    apply_reset();
    @(negedge clk);
    drive_a(1, 1, 0, 10'h000, 16'h0A0A);
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++;
      $display("FAIL wrap_wr0: got %b want 10", {a_ready, b_ready});
    end
    @(negedge clk);
    drive_a(1, 0, 0, 10'h3FF, 16'h0);
    drive_b(1, 1, 0, 10'h3FF, 16'hBEEF);
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b01) begin
      errors++;
      $display("FAIL cont_b_first: got %b want 01", {a_ready, b_ready});
    end
    @(negedge clk);
    drive_b(0, 0, 0, 10'h0, 16'h0);
    #1;
    checks++;
    if ({a_ready, b_ready, b_rvalid} !== 3'b100) begin
      errors++;
      $display("FAIL cont_a_next: got %b want 100", {a_ready, b_ready, b_rvalid});
    end
    @(negedge clk);
    drive_a(1, 0, 0, 10'h000, 16'h0);
    #1;
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL cont_rdata: got rvalid=%b rdata=%h want 1 beef", a_rvalid, a_rdata);
    end
    @(negedge clk);
    drive_a(0, 0, 0, 10'h0, 16'h0);
    #1;
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'h0A0A) begin
      errors++;
      $display("FAIL wrap_rdata0: got rvalid=%b rdata=%h want 1 0a0a", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    drive_a(1, 0, 1, 10'h005, 16'h0);
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_beat: got %b want 1", a_ready);
    end
    @(negedge clk);
    drive_a(0, 0, 0, 10'h0, 16'h0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00 || a_rdata !== 16'h0) begin
      errors++;
      $display("FAIL mid_clear: got %b rdata=%h want 00 0000", {a_rvalid, b_rvalid}, a_rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL mid_norvalid: got %b want 00", {a_rvalid, b_rvalid});
    end
    @(negedge clk);
    drive_a(1, 0, 0, 10'h005, 16'h0);
    drive_b(1, 0, 0, 10'h3FF, 16'h0);
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++;
      $display("FAIL mid_rr: got %b want 10", {a_ready, b_ready});
    end
    @(negedge clk);
    drive_a(0, 0, 0, 10'h0, 16'h0);
    #1;
    checks++;
    if ({a_rvalid, b_ready} !== 2'b11 || a_rdata !== 16'h1234) begin
      errors++;
      $display("FAIL mid_keep_a: got %b rdata=%h want 11 1234", {a_rvalid, b_ready}, a_rdata);
    end
    @(negedge clk);
    drive_b(0, 0, 0, 10'h0, 16'h0);
    #1;
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b01 || b_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL mid_keep_b: got %b rdata=%h want 01 beef", {a_rvalid, b_rvalid}, b_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_lock_handoff();
    test_lock_idle();
    test_contention_wrap();
    test_reset_midop();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port, synchronous-read internal RAM in the microinstruction store (16 bit x 1024, 10-bit address).
- Owns the RAM instance and grants at most one access per cycle, round-robin between requester A (microsequencer fetch) and requester B (loader/debug).
- Supports a bounded lock so a requester can issue back-to-back beats.
- Returns read data with fixed 1-cycle latency to the issuing requester.

Parameters:
RAM_WIDTH, 16, data word width
RAM_DEPTH, 1024, number of words
ADDR_SIZE, 10, address width (RAM_DEPTH = 2**ADDR_SIZE)
MAX_LOCK, 8, max consecutive locked beats before forced hand-off when the other side waits (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
a_valid  in  1  A requests an access this cycle
a_ready  out  1  A's access accepted this cycle (combinational from valids/state)
a_we  in  1  1 = write, 0 = read
a_lock  in  1  request to keep grant for the next beat
a_addr  in  ADDR_SIZE  A address
a_wdata  in  RAM_WIDTH  A write data
a_rvalid  out  1  A read data valid
a_rdata  out  RAM_WIDTH  A read data
b_valid, b_ready, b_we, b_lock, b_addr, b_wdata, b_rvalid, b_rdata  same as A for requester B

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n. This is fixed.
- Reset values: all outputs 0; owner=NONE; rr=A; lock_cnt=0; rvalid pipeline cleared. RAM contents are not reset.
- Handshake:
  - Beat occurs when x_valid && x_ready.
  - Requester holds valid/we/addr/wdata/lock stable until ready.
  - ready may depend on valid; valid must not depend on ready.
  - At most one of a_ready/b_ready is high in any cycle.
- Arbitration, evaluated every cycle:
  - LOCKED_x, x_valid=1, and (lock_cnt<MAX_LOCK or other side idle): grant x.
  - LOCKED_x, lock_cnt==MAX_LOCK, other side valid: grant other side; leave lock.
  - LOCKED_x, x_valid=0: lock released immediately; normal arbitration applies the same cycle.
  - Normal, both valid: grant side pointed to by rr.
  - Normal, one valid: grant it.
  - Normal, none valid: no grant.
- Pointer update: after any granted beat, rr points to the non-granted side.
- Lock state machine:
  - States are NONE, LOCKED_A, LOCKED_B.
  - A granted beat with x_lock=1 enters or stays in LOCKED_x. lock_cnt=1 on entry, else +1, saturating at MAX_LOCK.
  - A granted beat with x_lock=0 returns to NONE and sets lock_cnt=0.
  - Forced hand-off: the new owner's lock bit decides the next state.
- RAM control:
  - wr_enb = beat && we.
  - rd_enb = beat && !we.
  - addr and data_in are muxed from the granted side.
- Read latency:
  - x_rvalid is high exactly in the cycle after x's read beat, for one cycle.
  - a_rdata and b_rdata are both driven from the RAM output register; content is meaningful only with the matching rvalid.
  - No response for writes.
- Ordering: a write in cycle N followed by a read of the same address in N+1 returns the new data. Reads and writes from one side are never reordered.
- Reset mid-operation: an in-flight read produces no rvalid after reset is released. A lock in progress is dropped.

Decomposition:
- Shared package ram_arb_pkg holds:
  - owner state encoding: OWN_NONE=2'd0, OWN_A=2'd1, OWN_B=2'd2
  - requester index constants: REQ_A=0, REQ_B=1
  - default widths
- One sub-module, ram_sp_core: single-port RAM with synchronous write, registered read, rd_enb/wr_enb, no reset on the array. It is instantiated once inside the arbiter.

Test Plan:
- Reset, then idle: all outputs 0; then A writes 0x1234 @0x005, next cycle A reads 0x005 -> a_rvalid=1 one cycle later, a_rdata=0x1234, b_rvalid stays 0.
- A and B both valid reads every cycle, no lock, from reset -> grants alternate A,B,A,B; each rvalid returns on the side that issued one cycle after its beat.
- A locks (a_lock=1) continuously with B valid, MAX_LOCK=8 -> A gets 8 consecutive beats, 9th cycle grants B, then alternation resumes.
- A locks, B idle for 20 cycles -> A granted all 20 beats; B raises valid -> B granted within 1 cycle once lock_cnt is saturated.
- Same-cycle contention write/read: B writes 0xBEEF @0x3FF while A waits, then A reads 0x3FF -> a_rdata=0xBEEF. Address wrap: 0x3FF and 0x000 keep distinct contents.
- rst_n asserted the cycle after an A read beat -> no a_rvalid after release; state returns to NONE, rr=A; RAM data written before reset reads back unchanged.
